// File: rtl/oqpsk_shaper_param.sv
// BPSK/QPSK/OQPSK pulse shaper: bit FIFO, per-rail symbol chains and a serial
// multiplier-free FIR that produces one saturated I/Q sample per request.
module oqpsk_shaper_param #(
  parameter int OUT_W      = 13,
  parameter int COEF_W     = 12,
  parameter int SPS        = 4,
  parameter int SPAN       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_en,
  input  logic [1:0]                     i_mode,
  input  logic                           i_bit,
  input  logic                           i_bit_valid,
  output logic                           o_bit_ready,
  input  logic                           i_req_sample,
  output logic                           o_ack,
  output logic [OUT_W-1:0]               o_i,
  output logic [OUT_W-1:0]               o_q,
  input  logic                           i_coef_we,
  input  logic [$clog2(SPS*SPAN)-1:0]    i_coef_addr,
  input  logic [COEF_W-1:0]              i_coef_data,
  output logic                           o_underrun
);
  localparam int TAPS  = SPS * SPAN;
  localparam int A_W   = $clog2(TAPS);
  localparam int ACC_W = COEF_W + $clog2(SPAN) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int K_W   = $clog2(SPS);
  localparam int J_W   = (SPAN > 1) ? $clog2(SPAN) : 1;
  localparam int HALF  = SPS / 2;
  localparam int SAT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic signed [SAT_W-1:0] MAX_V =
    $signed({{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [SAT_W-1:0] MIN_V = ~MAX_V;

  typedef enum logic [1:0] {StIdle, StFetch, StAcc, StDone} state_e;

  state_e                   r_state, w_state_next;
  logic                     r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]         r_count;
  logic [SPAN-1:0][1:0]     r_chain_i, r_chain_q;
  logic [1:0]               r_pend;
  logic [K_W-1:0]           r_k;
  logic [J_W-1:0]           r_j;
  logic                     r_oq, r_underrun, r_en_q;
  logic signed [ACC_W-1:0]  r_acc_i, r_acc_q;
  logic [OUT_W-1:0]         r_i, r_q;
  logic signed [COEF_W-1:0] r_coef [TAPS];

  logic                     w_full, w_push, w_fetch, w_need2, w_oq_in, w_have, w_pop;
  logic [CNT_W-1:0]         w_pop_n;
  logic [1:0]               w_sym_i, w_sym_q;
  logic [A_W-1:0]           w_idx_i, w_idx_q;
  logic signed [ACC_W-1:0]  w_sum_i, w_sum_q;

  function automatic logic [1:0] to_sym(input logic b);
    return b ? 2'b01 : 2'b11;
  endfunction

  function automatic logic signed [ACC_W-1:0] mac(input logic signed [ACC_W-1:0] acc,
                                                  input logic [1:0] sym,
                                                  input logic signed [COEF_W-1:0] c);
    logic signed [ACC_W-1:0] ext;
    ext = ACC_W'(c);
    if (sym == 2'b01)      return acc + ext;
    else if (sym == 2'b11) return acc - ext;
    else                   return acc;
  endfunction

  function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic signed [SAT_W-1:0] e;
    e = SAT_W'(v);
    if (e > MAX_V)      return OUT_W'(MAX_V);
    else if (e < MIN_V) return OUT_W'(MIN_V);
    else                return OUT_W'(e);
  endfunction

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push      = i_bit_valid && !w_full;
  assign w_fetch     = (r_state == StFetch) && i_en;
  assign w_need2     = (i_mode != 2'd0);
  assign w_oq_in     = i_mode[1];
  assign w_have      = w_need2 ? (r_count >= CNT_W'(2)) : (r_count >= CNT_W'(1));
  assign w_pop       = w_fetch && (r_k == '0) && w_have;
  assign w_pop_n     = w_pop ? (w_need2 ? CNT_W'(2) : CNT_W'(1)) : '0;
  assign w_sym_i     = w_have ? to_sym(r_fifo[r_rd_ptr]) : 2'b00;
  assign w_sym_q     = (w_have && w_need2) ? to_sym(r_fifo[r_rd_ptr + PTR_W'(1)]) : 2'b00;

  assign o_bit_ready = !w_full;
  assign o_ack       = (r_state == StDone) && i_en;
  assign o_i         = r_i;
  assign o_q         = r_q;
  assign o_underrun  = r_underrun;

  always_comb begin
    int kq, ti, tq;
    kq = int'(r_k) + (r_oq ? HALF : 0);
    if (kq >= SPS) kq = kq - SPS;
    ti = int'(r_k) + int'(r_j) * SPS;
    tq = kq + int'(r_j) * SPS;
    w_idx_i = A_W'(ti);
    w_idx_q = A_W'(tq);
    w_sum_i = mac(r_acc_i, r_chain_i[r_j], r_coef[w_idx_i]);
    w_sum_q = mac(r_acc_q, r_chain_q[r_j], r_coef[w_idx_q]);
  end

  // DONE doubles as the idle slot so a held request repeats every SPAN+2 cycles.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_req_sample) w_state_next = StFetch;
      StFetch: w_state_next = StAcc;
      StAcc:   if (r_j == J_W'(SPAN - 1)) w_state_next = StDone;
      StDone:  w_state_next = i_req_sample ? StFetch : StIdle;
      default: w_state_next = StIdle;
    endcase
    if (!i_en) w_state_next = StIdle;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_en_q  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_en_q  <= i_en;
    end
  end

  // The FIFO is flushed once as EN falls so bits can be preloaded while EN stays low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int n = 0; n < FIFO_DEPTH; n++) r_fifo[n] <= 1'b0;
    end else if (!i_en && r_en_q) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= i_bit;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
      r_count  <= r_count + CNT_W'(w_push) - w_pop_n;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain_i  <= '0;
      r_chain_q  <= '0;
      r_pend     <= '0;
      r_k        <= '0;
      r_oq       <= 1'b0;
      r_underrun <= 1'b0;
    end else if (!i_en) begin
      r_chain_i  <= '0;
      r_chain_q  <= '0;
      r_pend     <= '0;
      r_k        <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_fetch) begin
        r_oq <= w_oq_in;
        if (r_k == '0) begin
          for (int j = SPAN - 1; j > 0; j--) r_chain_i[j] <= r_chain_i[j-1];
          r_chain_i[0] <= w_sym_i;
          if (!w_have) r_underrun <= 1'b1;
          if (w_oq_in) begin
            r_pend <= w_sym_q;
          end else begin
            for (int j = SPAN - 1; j > 0; j--) r_chain_q[j] <= r_chain_q[j-1];
            r_chain_q[0] <= w_sym_q;
          end
        end else if (w_oq_in && (r_k == K_W'(HALF))) begin
          for (int j = SPAN - 1; j > 0; j--) r_chain_q[j] <= r_chain_q[j-1];
          r_chain_q[0] <= r_pend;
        end
      end
      if (r_state == StDone) r_k <= (r_k == K_W'(SPS - 1)) ? '0 : r_k + K_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_j     <= '0;
      r_i     <= '0;
      r_q     <= '0;
    end else if (i_en) begin
      if (r_state == StFetch) begin
        r_acc_i <= '0;
        r_acc_q <= '0;
        r_j     <= '0;
      end else if (r_state == StAcc) begin
        r_acc_i <= w_sum_i;
        r_acc_q <= w_sum_q;
        r_j     <= r_j + J_W'(1);
        if (r_j == J_W'(SPAN - 1)) begin
          r_i <= sat(w_sum_i);
          r_q <= sat(w_sum_q);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int t = 0; t < TAPS; t++) r_coef[t] <= '0;
    end else if (!i_en && i_coef_we) begin
      r_coef[i_coef_addr] <= i_coef_data;
    end
  end

endmodule

// File: tb/tb_oqpsk_shaper_param.sv
// Directed bench for oqpsk_shaper_param: table of shaping scenarios plus
// hand-written reset, latency, back-to-back and FIFO-full sequences.
module tb_oqpsk_shaper_param;
  localparam int OUT_W = 13;
  localparam int COEF_W = 12;
  localparam int A_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              bit_in = 1'b0;
  logic              bit_valid = 1'b0;
  logic              bit_ready;
  logic              req = 1'b0;
  logic              ack;
  logic [OUT_W-1:0]  o_i, o_q;
  logic              coef_we = 1'b0;
  logic [A_W-1:0]    coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              underrun;

  int n_vec = 0;
  int n_err = 0;

  oqpsk_shaper_param #(
    .OUT_W(13), .COEF_W(12), .SPS(4), .SPAN(4), .FIFO_DEPTH(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode),
    .i_bit(bit_in), .i_bit_valid(bit_valid), .o_bit_ready(bit_ready),
    .i_req_sample(req), .o_ack(ack), .o_i(o_i), .o_q(o_q),
    .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
    .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  // sel 0: coef[0]=cval, rest 0; sel 1: all cval; sel 2: ramp 100*t-700
  typedef struct {
    int          sel;
    int          cval;
    int          md;
    int          nbits;
    logic [15:0] bits;
    int          nsamp;
    int          exp_i;
    int          exp_q;
    int          exp_und;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int coef_val(input int sel, input int cval, input int t);
    if (sel == 0) return (t == 0) ? cval : 0;
    if (sel == 1) return cval;
    return 100 * t - 700;
  endfunction

  task automatic load_coefs(input int sel, input int cval);
    en = 1'b0;
    tick();
    tick();
    for (int t = 0; t < 16; t++) begin
      coef_we   = 1'b1;
      coef_addr = A_W'(t);
      coef_data = COEF_W'(coef_val(sel, cval, t));
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic push_bits(input int n, input logic [15:0] bits);
    for (int b = 0; b < n; b++) begin
      bit_valid = 1'b1;
      bit_in    = bits[b];
      tick();
    end
    bit_valid = 1'b0;
  endtask

  // Returns the number of rising edges from request to ACK, or -1 on timeout.
  task automatic do_sample(output int lat);
    lat = -1;
    req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) req = 1'b0;
      if (ack) begin
        lat = c;
        break;
      end
    end
    req = 1'b0;
  endtask

  function automatic int sv(input logic [OUT_W-1:0] v);
    return int'($signed(v));
  endfunction

  initial begin
    int lat, acks, accepted, first_ack, second_ack;
    logic rdy;

    vecs[0]  = '{0, 1000, 1, 2, 16'h0001, 1, 1000, -1000, 0};
    vecs[1]  = '{0, 1000, 2, 2, 16'h0003, 1, 1000, 0, 0};
    vecs[2]  = '{0, 1000, 2, 2, 16'h0003, 2, 0, 0, 0};
    vecs[3]  = '{0, 1000, 2, 2, 16'h0003, 3, 0, 1000, 0};
    vecs[4]  = '{0, 1000, 1, 0, 16'h0000, 1, 0, 0, 1};
    vecs[5]  = '{1, 2047, 1, 8, 16'h00FF, 13, 4095, 4095, 0};
    vecs[6]  = '{1, 2047, 1, 8, 16'h0000, 13, -4096, -4096, 0};
    vecs[7]  = '{0, 1000, 0, 1, 16'h0000, 1, -1000, 0, 0};
    vecs[8]  = '{0, 1000, 3, 2, 16'h0001, 3, 0, -1000, 0};
    vecs[9]  = '{1, 2047, 1, 4, 16'h0005, 5, 4094, -4094, 0};
    vecs[10] = '{1, 2047, 1, 2, 16'h0001, 5, 2047, -2047, 1};
    vecs[11] = '{2, 0, 1, 4, 16'h0009, 6, 400, -400, 0};
    vecs[12] = '{2, 0, 2, 2, 16'h0003, 3, -500, -700, 0};

    tick();
    check("reset_ack", int'(ack), 0);
    check("reset_i", sv(o_i), 0);
    check("reset_q", sv(o_q), 0);
    check("reset_underrun", int'(underrun), 0);
    check("reset_ready", int'(bit_ready), 1);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 13; v++) begin
      load_coefs(vecs[v].sel, vecs[v].cval);
      mode = 2'(vecs[v].md);
      en = 1'b1;
      tick();
      push_bits(vecs[v].nbits, vecs[v].bits);
      lat = -1;
      for (int s = 0; s < vecs[v].nsamp; s++) do_sample(lat);
      check($sformatf("vec%0d_latency", v), lat, 6);
      check($sformatf("vec%0d_i", v), sv(o_i), vecs[v].exp_i);
      check($sformatf("vec%0d_q", v), sv(o_q), vecs[v].exp_q);
      check($sformatf("vec%0d_underrun", v), int'(underrun), vecs[v].exp_und);
    end

    // Asynchronous reset while accumulating, with a full FIFO and nonzero I/Q.
    push_bits(8, 16'h00AA);
    check("full_ready_low", int'(bit_ready), 0);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_acc_ack", int'(ack), 0);
    check("rst_acc_i", sv(o_i), 0);
    check("rst_acc_q", sv(o_q), 0);
    check("rst_acc_ready", int'(bit_ready), 1);
    tick();
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack) acks++;
    end
    check("no_ack_after_rst", acks, 0);
    do_sample(lat);
    check("first_req_latency", lat, 6);

    // Held request: ACKs every SPAN+2 cycles.
    first_ack = -1;
    second_ack = -1;
    req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (ack) begin
        if (first_ack < 0) first_ack = c;
        else if (second_ack < 0) second_ack = c;
      end
    end
    req = 1'b0;
    check("b2b_first", first_ack, 6);
    check("b2b_period", second_ack - first_ack, 6);

    // FIFO fill with EN low, coefficient write ignored with EN high.
    load_coefs(0, 1000);
    mode = 2'd0;
    accepted = 0;
    for (int b = 0; b < 9; b++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      rdy       = bit_ready;
      tick();
      if (rdy) accepted++;
      if (b == 6) check("ready_before_8th", int'(bit_ready), 1);
    end
    bit_valid = 1'b0;
    check("fifo_accepted", accepted, 8);
    check("fifo_ready_full", int'(bit_ready), 0);
    en = 1'b1;
    coef_we = 1'b1;
    coef_addr = '0;
    coef_data = COEF_W'(5);
    tick();
    coef_we = 1'b0;
    do_sample(lat);
    check("coef_we_ignored_i", sv(o_i), 1000);
    for (int s = 2; s <= 29; s++) do_sample(lat);
    check("sym8_i", sv(o_i), 1000);
    check("sym8_underrun", int'(underrun), 0);
    for (int s = 30; s <= 33; s++) do_sample(lat);
    check("sym9_i", sv(o_i), 0);
    check("sym9_underrun", int'(underrun), 1);
    tick();
    check("underrun_sticky", int'(underrun), 1);
    en = 1'b0;
    tick();
    check("underrun_clr_en", int'(underrun), 0);
    check("en_low_i_hold", sv(o_i), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got %0d errors so far", n_err);
    $fatal(1);
  end

endmodule

// File: doc/oqpsk_shaper_param.md
OQPSK_SHAPER_PARAM -- requirements
Module: oqpsk_shaper_param

Interface
REQ-001 Parameter OUT_W, 13: signed width of I and Q outputs.
REQ-002 Parameter COEF_W, 12: signed width of each pulse-shaping coefficient.
REQ-003 Parameter SPS, 4: samples per symbol; even, ≥2.
REQ-004 Parameter SPAN, 4: filter span in symbols; tap count TAPS = SPS*SPAN.
REQ-005 Parameter FIFO_DEPTH, 8: input bit FIFO depth; power of two.
REQ-006 CLK  in  1  sole clock; all state on rising edge.
REQ-007 RST  in  1  asynchronous, active-low reset.
REQ-008 EN  in  1  enable; low = idle and flush.
REQ-009 MODE  in  2  0=BPSK, 1=QPSK, 2=OQPSK, 3=treated as OQPSK.
REQ-010 Bit_In / BIT_VALID / BIT_READY  in/in/out  1/1/1  bit push; transfer when VALID&&READY.
REQ-011 REQ_SAMPLE  in  1  request one output sample (level sampled each cycle).
REQ-012 ACK  out  1  one-cycle pulse; I/Q valid from this cycle.
REQ-013 I, Q  out  OUT_W  shaped baseband samples, signed, registered.
REQ-014 COEF_WE / COEF_ADDR / COEF_DATA  in  1 / clog2(TAPS) / COEF_W  coefficient write port.
REQ-015 UNDERRUN  out  1  sticky: a symbol was needed with insufficient FIFO bits.

Function
REQ-016 FIFO: BIT_READY = !full; push when full rejected even if a pop occurs the same cycle; simultaneous push/pop when not full keeps count.
REQ-017 Mapping: bit 1 -> +1, bit 0 -> -1; missing symbol (underrun) -> 0, UNDERRUN set.
REQ-018 Symbol fetch at phase k==0: BPSK pops 1 bit into I chain, Q chain receives 0; QPSK/OQPSK pop 2 bits, first -> I, second -> Q (QPSK) or Q-pending (OQPSK); both bits required else both symbols 0, no pop.
REQ-019 OQPSK: Q-pending shifts into Q chain at k==SPS/2.
REQ-020 Each chain is a SPAN-deep symbol shift register, entry 0 newest.
REQ-021 I = sum_j symI[j]*coef[k + j*SPS]; Q uses phase kq = k (BPSK/QPSK) or (k+SPS/2) mod SPS (OQPSK); multiplies realised as add/subtract/skip.
REQ-022 Accumulator width COEF_W+clog2(SPAN)+1; result saturated to signed OUT_W range (sign-extended if narrower).
REQ-023 FSM IDLE -> FETCH (1 cycle: symbol update) -> ACC (SPAN cycles, one tap per chain per cycle) -> DONE (I,Q registered, ACK=1) -> IDLE; k increments mod SPS in DONE.
REQ-024 Latency: REQ_SAMPLE seen high in IDLE at cycle n -> ACK at cycle n+SPAN+2.
REQ-025 REQ_SAMPLE outside IDLE ignored; held high yields back-to-back samples every SPAN+2 cycles.
REQ-026 EN low: FSM to IDLE within 1 cycle, chains, pending, k, FIFO cleared, UNDERRUN cleared, I/Q hold last value, ACK=0.
REQ-027 Coefficient writes accepted only when EN low; ignored when EN high.
REQ-028 MODE sampled only in FETCH; changing MODE mid-sample has no effect until next FETCH.

Reset
REQ-029 RST low asynchronously forces: I=Q=0, ACK=0, UNDERRUN=0, BIT_READY=1, FIFO empty, chains/pending=0, k=0, all coefficients=0, FSM=IDLE; mid-computation results discarded.
REQ-030 First REQ_SAMPLE after RST deassertion obeys REQ-024 exactly.

Verification
REQ-031 RST low during ACC -> same cycle ACK=0, I=Q=0, BIT_READY=1; no ACK after release until new REQ.
REQ-032 Defaults, coef[0]=1000 else 0, MODE=1, push 1,0, REQ at n -> ACK at n+6, I=+1000, Q=-1000.
REQ-033 All coef=2047, MODE=1, bits all 1, four samples per symbol; at 4th symbol's k=0 sample raw 8188 -> I=Q=4095; bits all 0 -> I=Q=-4096.
REQ-034 coef[0]=1000, MODE=2, push 1,1, three REQs -> samples k=0,1,2: I=1000,0,0; Q=0,0,1000.
REQ-035 MODE=1, FIFO empty, REQ -> ACK with I=Q=0, UNDERRUN=1; stays 1 until EN low.
REQ-036 EN=0, push 9 bits with VALID constant -> BIT_READY low after 8th accepted; 9th not stored; COEF_WE with EN=1 leaves coefficient unchanged.
